// File: rtl/tile_pkg.sv
// Shared widths, rounding and bus-lane helpers for the systolic tile array.
package tile_pkg;

  localparam int unsigned DefRows      = 2;
  localparam int unsigned DefCols      = 2;
  localparam int unsigned DefABits     = 8;
  localparam int unsigned DefBBits     = 19;
  localparam int unsigned DefDBits     = 32;
  localparam int unsigned DefShiftBits = 4;

  // Wide enough that a sign-extended accumulator plus rounding bias never overflows.
  localparam int unsigned RoundBits = 65;

  // Round-half-up arithmetic right shift; s == 0 passes x through untouched.
  function automatic logic signed [RoundBits-1:0] round_shift(
    input logic signed [RoundBits-1:0] x,
    input logic        [7:0]           s
  );
    logic signed [RoundBits-1:0] bias;
    if (s == 8'd0) begin
      return x;
    end
    bias = {{(RoundBits-1){1'b0}}, 1'b1} << (s - 8'd1);
    return (x + bias) >>> s;
  endfunction

  // LSB position of lane idx inside a packed bus of width-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pe_cell.sv
// One processing element: registered forwarding plus a double-buffered MAC accumulator.
module pe_cell
  import tile_pkg::*;
#(
  parameter int unsigned A_BITS     = DefABits,
  parameter int unsigned B_BITS     = DefBBits,
  parameter int unsigned D_BITS     = DefDBits,
  parameter int unsigned SHIFT_BITS = DefShiftBits
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [A_BITS-1:0]     a_i,
  input  logic [B_BITS-1:0]     b_i,
  input  logic [D_BITS-1:0]     d_i,
  input  logic                  prop_i,
  input  logic [SHIFT_BITS-1:0] shift_i,
  input  logic                  valid_i,
  output logic [A_BITS-1:0]     a_o,
  output logic [B_BITS-1:0]     b_o,
  output logic [D_BITS-1:0]     c_o,
  output logic                  prop_o,
  output logic [SHIFT_BITS-1:0] shift_o,
  output logic                  valid_o
);

  // Product width covering the full-precision signed product.
  localparam int unsigned PW = (A_BITS + B_BITS > D_BITS) ? A_BITS + B_BITS : D_BITS;

  logic [A_BITS-1:0]     a_q;
  logic [B_BITS-1:0]     b_q, b_d;
  logic [D_BITS-1:0]     c_q, c_d;
  logic [D_BITS-1:0]     c1_q, c1_d;
  logic [D_BITS-1:0]     c2_q, c2_d;
  logic                  prop_q, prop_d;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;
  logic                  valid_q;

  logic signed [PW-1:0]  a_ext, b_ext;
  logic [D_BITS-1:0]     mac;

  assign a_ext = PW'($signed(a_i));
  assign b_ext = PW'($signed(b_i));
  // Accumulation wraps modulo 2^D_BITS, so only the low bits of the product matter.
  assign mac   = D_BITS'(a_ext * b_ext);

  // Next-state: the idle accumulator drains and reloads from d while the other one accumulates.
  always_comb begin
    b_d     = b_q;
    c_d     = c_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    prop_d  = prop_q;
    shift_d = shift_q;
    if (valid_i) begin
      b_d     = b_i;
      prop_d  = prop_i;
      shift_d = shift_i;
      if (prop_i) begin
        c_d  = D_BITS'(round_shift(RoundBits'($signed(c1_q)), 8'(shift_i)));
        c1_d = d_i;
        c2_d = c2_q + mac;
      end else begin
        c_d  = D_BITS'(round_shift(RoundBits'($signed(c2_q)), 8'(shift_i)));
        c2_d = d_i;
        c1_d = c1_q + mac;
      end
    end
  end

  // State registers; the a pipeline advances every cycle regardless of valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      prop_q  <= 1'b0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_i;
      b_q     <= b_d;
      c_q     <= c_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      prop_q  <= prop_d;
      shift_q <= shift_d;
      valid_q <= valid_i;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign c_o     = c_q;
  assign prop_o  = prop_q;
  assign shift_o = shift_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/tile_array.sv
// ROWS x COLS systolic grid: a flows east, b/d/control flow south, one register per hop.
module tile_array
  import tile_pkg::*;
#(
  parameter int unsigned ROWS       = DefRows,
  parameter int unsigned COLS       = DefCols,
  parameter int unsigned A_BITS     = DefABits,
  parameter int unsigned B_BITS     = DefBBits,
  parameter int unsigned D_BITS     = DefDBits,
  parameter int unsigned SHIFT_BITS = DefShiftBits
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ROWS*A_BITS-1:0]     io_in_a,
  input  logic [COLS*B_BITS-1:0]     io_in_b,
  input  logic [COLS*D_BITS-1:0]     io_in_d,
  input  logic [COLS-1:0]            io_in_control_propagate,
  input  logic [COLS*SHIFT_BITS-1:0] io_in_control_shift,
  input  logic [COLS-1:0]            io_in_valid,
  output logic [ROWS*A_BITS-1:0]     io_out_a,
  output logic [COLS*B_BITS-1:0]     io_out_b,
  output logic [COLS*D_BITS-1:0]     io_out_c,
  output logic [COLS-1:0]            io_out_control_propagate,
  output logic [COLS*SHIFT_BITS-1:0] io_out_control_shift,
  output logic [COLS-1:0]            io_out_valid
);

  // Horizontal links indexed [row][col]; vertical links indexed [row][col], row ROWS is the exit.
  logic [A_BITS-1:0]     a_w [ROWS][COLS+1];
  logic [B_BITS-1:0]     b_w [ROWS+1][COLS];
  logic [D_BITS-1:0]     c_w [ROWS+1][COLS];
  logic                  p_w [ROWS+1][COLS];
  logic [SHIFT_BITS-1:0] s_w [ROWS+1][COLS];
  logic                  v_w [ROWS+1][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row_io
    assign a_w[r][0] = io_in_a[lane_lsb(r, A_BITS) +: A_BITS];
    assign io_out_a[lane_lsb(r, A_BITS) +: A_BITS] = a_w[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_io
    assign b_w[0][c] = io_in_b[lane_lsb(c, B_BITS) +: B_BITS];
    assign c_w[0][c] = io_in_d[lane_lsb(c, D_BITS) +: D_BITS];
    assign p_w[0][c] = io_in_control_propagate[c];
    assign s_w[0][c] = io_in_control_shift[lane_lsb(c, SHIFT_BITS) +: SHIFT_BITS];
    assign v_w[0][c] = io_in_valid[c];

    assign io_out_b[lane_lsb(c, B_BITS) +: B_BITS]                 = b_w[ROWS][c];
    assign io_out_c[lane_lsb(c, D_BITS) +: D_BITS]                 = c_w[ROWS][c];
    assign io_out_control_propagate[c]                             = p_w[ROWS][c];
    assign io_out_control_shift[lane_lsb(c, SHIFT_BITS) +: SHIFT_BITS] = s_w[ROWS][c];
    assign io_out_valid[c]                                         = v_w[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      pe_cell #(
        .A_BITS     (A_BITS),
        .B_BITS     (B_BITS),
        .D_BITS     (D_BITS),
        .SHIFT_BITS (SHIFT_BITS)
      ) u_pe (
        .clk_i   (clock),
        .rst_ni  (reset),
        .a_i     (a_w[r][c]),
        .b_i     (b_w[r][c]),
        .d_i     (c_w[r][c]),
        .prop_i  (p_w[r][c]),
        .shift_i (s_w[r][c]),
        .valid_i (v_w[r][c]),
        .a_o     (a_w[r][c+1]),
        .b_o     (b_w[r+1][c]),
        .c_o     (c_w[r+1][c]),
        .prop_o  (p_w[r+1][c]),
        .shift_o (s_w[r+1][c]),
        .valid_o (v_w[r+1][c])
      );
    end
  end

endmodule

// File: tb/tb_tile_array.sv
// Directed bench: a 2x2 array for reset/latency/mid-run reset, a 1x1 array for MAC arithmetic.
module tb_tile_array;

  logic clk;
  logic rst_n;

  // 2x2 instance signals
  logic [15:0] u2_in_a;
  logic [37:0] u2_in_b;
  logic [63:0] u2_in_d;
  logic [1:0]  u2_in_p;
  logic [7:0]  u2_in_s;
  logic [1:0]  u2_in_v;
  logic [15:0] u2_out_a;
  logic [37:0] u2_out_b;
  logic [63:0] u2_out_c;
  logic [1:0]  u2_out_p;
  logic [7:0]  u2_out_s;
  logic [1:0]  u2_out_v;

  // 1x1 instance signals
  logic [7:0]  u1_in_a;
  logic [18:0] u1_in_b;
  logic [31:0] u1_in_d;
  logic        u1_in_p;
  logic [3:0]  u1_in_s;
  logic        u1_in_v;
  logic [7:0]  u1_out_a;
  logic [18:0] u1_out_b;
  logic [31:0] u1_out_c;
  logic        u1_out_p;
  logic [3:0]  u1_out_s;
  logic        u1_out_v;

  int n_total;
  int n_bad;

  tile_array #(.ROWS(2), .COLS(2)) u_dut2 (
    .clock                    (clk),
    .reset                    (rst_n),
    .io_in_a                  (u2_in_a),
    .io_in_b                  (u2_in_b),
    .io_in_d                  (u2_in_d),
    .io_in_control_propagate  (u2_in_p),
    .io_in_control_shift      (u2_in_s),
    .io_in_valid              (u2_in_v),
    .io_out_a                 (u2_out_a),
    .io_out_b                 (u2_out_b),
    .io_out_c                 (u2_out_c),
    .io_out_control_propagate (u2_out_p),
    .io_out_control_shift     (u2_out_s),
    .io_out_valid             (u2_out_v)
  );

  tile_array #(.ROWS(1), .COLS(1)) u_dut1 (
    .clock                    (clk),
    .reset                    (rst_n),
    .io_in_a                  (u1_in_a),
    .io_in_b                  (u1_in_b),
    .io_in_d                  (u1_in_d),
    .io_in_control_propagate  (u1_in_p),
    .io_in_control_shift      (u1_in_s),
    .io_in_valid              (u1_in_v),
    .io_out_a                 (u1_out_a),
    .io_out_b                 (u1_out_b),
    .io_out_c                 (u1_out_c),
    .io_out_control_propagate (u1_out_p),
    .io_out_control_shift     (u1_out_s),
    .io_out_valid             (u1_out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge they were updated on.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input int p, input int s, input int a, input int b, input int d);
    u1_in_v = 1'b1;
    u1_in_p = 1'(p);
    u1_in_s = 4'(s);
    u1_in_a = 8'(a);
    u1_in_b = 19'(b);
    u1_in_d = 32'(d);
    tick();
  endtask

  task automatic check_u2_zero(input string pfx);
    check_eq({pfx, "_out_a"}, 64'(u2_out_a), 64'h0);
    check_eq({pfx, "_out_b"}, 64'(u2_out_b), 64'h0);
    check_eq({pfx, "_out_c"}, u2_out_c, 64'h0);
    check_eq({pfx, "_out_p"}, 64'(u2_out_p), 64'h0);
    check_eq({pfx, "_out_s"}, 64'(u2_out_s), 64'h0);
    check_eq({pfx, "_out_v"}, 64'(u2_out_v), 64'h0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    u1_in_a = '0; u1_in_b = '0; u1_in_d = '0; u1_in_p = 1'b0; u1_in_s = '0; u1_in_v = 1'b0;

    // Reset held for three cycles under random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u2_in_a = 16'($urandom());
      u2_in_b = 38'({$urandom(), $urandom()});
      u2_in_d = {$urandom(), $urandom()};
      u2_in_p = 2'($urandom());
      u2_in_s = 8'($urandom());
      u2_in_v = 2'($urandom());
      u1_in_v = 1'($urandom());
      u1_in_d = $urandom();
      tick();
    end
    check_u2_zero("rst");
    check_eq("rst_u1_c", 64'(u1_out_c), 64'h0);
    check_eq("rst_u1_v", 64'(u1_out_v), 64'h0);

    // Release with valid low: nothing may emerge.
    u2_in_a = '0; u2_in_b = '0; u2_in_d = '0; u2_in_p = '0; u2_in_s = '0; u2_in_v = '0;
    u1_in_a = '0; u1_in_b = '0; u1_in_d = '0; u1_in_p = 1'b0; u1_in_s = '0; u1_in_v = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_valid", 64'(u2_out_v), 64'h0);
    end

    // Latency on 2x2: a crosses two columns, valid crosses two rows.
    u2_in_a = 16'h0005;
    u2_in_v = 2'b10;
    tick();
    u2_in_a = '0;
    u2_in_v = '0;
    check_eq("lat_a_t1", 64'(u2_out_a), 64'h0);
    check_eq("lat_v_t1", 64'(u2_out_v), 64'h0);
    tick();
    check_eq("lat_a_t2", 64'(u2_out_a), 64'h0005);
    check_eq("lat_v_t2", 64'(u2_out_v), 64'h2);
    tick();
    check_eq("lat_a_t3", 64'(u2_out_a), 64'h0);
    check_eq("lat_v_t3", 64'(u2_out_v), 64'h0);

    // MAC on 1x1: four 2*3 products into c2, then drain c2.
    for (int i = 0; i < 4; i++) step1(1, 0, 2, 3, 0);
    step1(0, 0, 2, 3, 0);
    check_eq("mac_c", 64'(u1_out_c), 64'd24);
    check_eq("mac_v", 64'(u1_out_v), 64'd1);
    check_eq("mac_p", 64'(u1_out_p), 64'd0);

    // Rounding: preload c1, drain with shift.
    step1(1, 0, 0, 0, 7);
    step1(1, 1, 0, 0, 0);
    check_eq("rnd_pos7_s1", 64'(u1_out_c), 64'd4);
    step1(1, 0, 0, 0, -7);
    step1(1, 1, 0, 0, 0);
    check_eq("rnd_neg7_s1", 64'(u1_out_c), 64'hFFFF_FFFD);
    step1(1, 0, 0, 0, 7);
    step1(1, 2, 0, 0, 0);
    check_eq("rnd_pos7_s2", 64'(u1_out_c), 64'd2);
    check_eq("rnd_shift_fwd", 64'(u1_out_s), 64'd2);

    // Wrap: 0x7FFFFFFF + 1*1 wraps to 0x80000000.
    step1(1, 0, 0, 0, 32'h7FFF_FFFF);
    step1(0, 0, 1, 1, 0);
    step1(1, 0, 0, 1, 0);
    check_eq("wrap_c", 64'(u1_out_c), 64'h8000_0000);

    // valid=0 holds forwarded data and drops valid.
    u1_in_v = 1'b0;
    u1_in_b = 19'd77;
    u1_in_d = 32'd123;
    tick();
    check_eq("hold_b", 64'(u1_out_b), 64'd1);
    check_eq("hold_c", 64'(u1_out_c), 64'h8000_0000);
    check_eq("hold_v", 64'(u1_out_v), 64'd0);

    // Signed wide product: 10 + (-128)*(-200000) = 25600010.
    step1(1, 0, 0, 0, 10);
    step1(0, 0, -128, -200000, 0);
    step1(1, 0, 0, 0, 0);
    check_eq("wide_prod", 64'(u1_out_c), 64'd25600010);

    // Mid-run reset on 2x2: full-rate stream, one reset cycle, then a directed run.
    for (int i = 0; i < 5; i++) begin
      u2_in_a = 16'($urandom());
      u2_in_b = 38'({$urandom(), $urandom()});
      u2_in_d = {$urandom(), $urandom()};
      u2_in_p = 2'($urandom());
      u2_in_s = 8'($urandom());
      u2_in_v = 2'b11;
      tick();
    end
    rst_n = 1'b0;
    tick();
    check_u2_zero("midrst");

    rst_n   = 1'b1;
    u2_in_a = {8'd2, 8'd1};
    u2_in_b = {19'd4, 19'd3};
    u2_in_d = '0;
    u2_in_s = '0;
    u2_in_p = 2'b11;
    u2_in_v = 2'b11;
    tick();
    check_eq("post_v_e1", 64'(u2_out_v), 64'h0);
    tick();
    check_eq("post_v_e2", 64'(u2_out_v), 64'h3);
    tick();
    tick();
    u2_in_p = 2'b00;
    tick();
    check_eq("post_c_d1", u2_out_c, 64'h0);
    check_eq("post_p_d1", 64'(u2_out_p), 64'h3);
    tick();
    check_eq("post_c_d2", u2_out_c, {32'd32, 32'd24});
    check_eq("post_p_d2", 64'(u2_out_p), 64'h0);
    tick();
    check_eq("post_c_d3", u2_out_c, {32'd12, 32'd12});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_array.md
TILE_ARRAY -- requirements
Module: tile_array

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ROWS, 2, PE rows (1..8).
- COLS, 2, PE columns (1..8).
- A_BITS, 8, signed activation width.
- B_BITS, 19, signed weight width.
- D_BITS, 32, signed accumulator/partial-sum width (dbits).
- SHIFT_BITS, 4, output rounding-shift width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock.
- reset, in, 1, synchronous active-low reset.
- io_in_a, in, ROWS*A_BITS, row activations; row r at bits [r*A_BITS +: A_BITS].
- io_in_b, in, COLS*B_BITS, column weights.
- io_in_d, in, COLS*D_BITS, column preload/partial sums.
- io_in_control_propagate, in, COLS, accumulator select per column.
- io_in_control_shift, in, COLS*SHIFT_BITS, rounding shift per column.
- io_in_valid, in, COLS, column valid.
- io_out_a, out, ROWS*A_BITS, activations leaving the last column.
- io_out_b, out, COLS*B_BITS, weights leaving the last row.
- io_out_c, out, COLS*D_BITS, results leaving the last row.
- io_out_control_propagate, out, COLS, propagate leaving the last row.
- io_out_control_shift, out, COLS*SHIFT_BITS, shift leaving the last row.
- io_out_valid, out, COLS, valid leaving the last row.
REQ-003 The block SHALL use one clock, clock; reset SHALL be synchronous and active-low, named reset.

Function
REQ-004 Grid SHALL contain ROWS x COLS PEs; a flows west to east along each row; b, d/c, propagate, shift and valid flow north to south within each column.
REQ-005 Every PE SHALL register its forwarded a, b, c, propagate, shift and valid: one cycle per hop.
REQ-006 Latency: io_out_a SHALL lag io_in_a by exactly COLS cycles; all column outputs SHALL lag their inputs by exactly ROWS cycles.
REQ-007 The d input of PE(r,c) for r>0 SHALL be the registered c output of PE(r-1,c); row 0 SHALL take io_in_d.
REQ-008 Each PE SHALL hold two D_BITS signed accumulators, c1 and c2.
REQ-009 On valid=1 with propagate=1: out_c <= round(c1, shift); c1 <= sext(d); c2 <= c2 + a*b.
REQ-010 On valid=1 with propagate=0: out_c <= round(c2, shift); c2 <= sext(d); c1 <= c1 + a*b.
REQ-011 On valid=0: c1, c2 and all forwarded data registers SHALL hold; forwarded valid SHALL be 0. The a pipeline SHALL advance every cycle regardless of valid.
REQ-012 Product a*b SHALL be signed full-precision; accumulation SHALL wrap modulo 2^D_BITS with no saturation.
REQ-013 round(x,s) SHALL be x for s=0; otherwise (x + 2^(s-1)) >>> s (arithmetic), truncated to D_BITS.
REQ-014 Columns SHALL operate independently; differing valid or propagate across columns SHALL be legal.

Reset
REQ-015 While reset=0 at a clock edge: c1, c2, every pipeline register and every output SHALL become 0, including io_out_valid=0 and io_out_control_propagate=0.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight data; the first post-reset io_out_valid=1 SHALL come only from input valid sampled after release.

Structure
REQ-017 Shared package tile_pkg SHALL hold default widths, the round function and the packed-bus slice helpers.
REQ-018 One sub-module, pe_cell, SHALL implement REQ-005 and REQ-008..REQ-013; tile_array SHALL be generate-instantiated wiring plus boundary connections only.

Verification
REQ-019 Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0; after release with valid=0 -> io_out_valid stays 0.
REQ-020 Latency (2x2): io_in_a row0=5 for one cycle -> io_out_a row0=5 exactly 2 cycles later; io_in_valid[1]=1 pulse -> io_out_valid[1]=1 exactly 2 cycles later.
REQ-021 MAC (1x1): 4 valid cycles, propagate=1, a=2, b=3, d=0; then one valid cycle, propagate=0, shift=0 -> io_out_c=24.
REQ-022 Rounding (1x1): accumulator 7, drain with shift=1 -> 4; accumulator -7, shift=1 -> -3.
REQ-023 Wrap: accumulator preloaded 0x7FFFFFFF plus a=1, b=1 -> drained value 0x80000000.
REQ-024 Mid-run reset (2x2): full-rate valid stream, reset=0 for 1 cycle -> next cycle all outputs 0; post-release results match the reference model with zero-initialised accumulators.
